acc_mac16: RTL

- Datapath accumulator that sits directly downstream of the 16-state accumulator controller and consumes its `state[3:0]` count.
- Each controller cycle presents one input/weight pair. The block multiplies the pair and accumulates 16 products plus a bias into one neuron pre-activation.
- At the end of each window it applies an arithmetic right shift, ReLU and unsigned saturation, then emits one activation byte with a one-cycle valid pulse.
- It checks that the incoming state sequence is contiguous. A broken window is discarded rather than producing a corrupt output.

---
 rtl/acc_mac16_if.sv | 27 ++
 rtl/acc_mac16.sv | 106 ++++++++++
 2 files changed

// File: rtl/acc_mac16_if.sv
// acc_mac16_if: controller-side bus of the 16-step MAC accumulator.
//   state          controller step index (0 = first product, 15 = last)
//   x_in, w_in     signed operand / weight for the current step
//   bias           signed bias, consumed with the step-0 product
//   y, y_valid     unsigned activation byte and its one-cycle strobe
//   seq_err        one-cycle pulse on a non-contiguous step sequence
interface acc_mac16_if #(
   parameter int unsigned DW = 8
);
   logic        [3:0]    state;
   logic signed [DW-1:0] x_in;
   logic signed [DW-1:0] w_in;
   logic signed [DW-1:0] bias;
   logic        [DW-1:0] y;
   logic                 y_valid;
   logic                 seq_err;

   modport master (
      output state, x_in, w_in, bias,
      input  y, y_valid, seq_err
   );

   modport slave (
      input  state, x_in, w_in, bias,
      output y, y_valid, seq_err
   );
endinterface

// File: rtl/acc_mac16.sv
// acc_mac16: accumulates 16 signed products plus a bias per window, then
// applies an arithmetic right shift, ReLU and unsigned saturation and emits
// one activation byte with a single-cycle valid strobe.
// Ports:
//   clk   rising-edge clock shared with the controller
//   rst   synchronous, active-high reset
//   bus   acc_mac16_if.slave (state/x_in/w_in/bias in, y/y_valid/seq_err out)
module acc_mac16 #(
   parameter int unsigned DW    = 8,
   parameter int unsigned ACCW  = 20,
   parameter int unsigned SHIFT = 4
) (
   input logic       clk,
   input logic       rst,
   acc_mac16_if.slave bus
);

   localparam int unsigned PW = 2 * DW;
   localparam logic signed [ACCW-1:0] YMAX = ACCW'((2 ** DW) - 1);

   // stage 1 registers
   logic signed [PW-1:0]   prod_q;
   logic        [3:0]      st_q;
   logic        [3:0]      prev_state;
   logic                   s1_vld;
   logic                   have_prev;
   logic                   err_q;
   logic                   win_vld;

   // stage 2 / output registers
   logic signed [ACCW-1:0] acc;
   logic        [DW-1:0]   fin_q;
   logic                   fin_vld;

   // combinational helpers
   logic signed [PW-1:0]   prod_c;
   logic                   viol_c;
   logic signed [ACCW-1:0] base_c;
   logic signed [ACCW-1:0] sum_c;
   logic signed [ACCW-1:0] shf_c;
   logic        [DW-1:0]   sat_c;

   // multiply, contiguity check, accumulate, shift and clamp
   always_comb begin
      prod_c = PW'(bus.x_in) * PW'(bus.w_in);
      viol_c = have_prev && (bus.state != 4'(prev_state + 4'd1));
      base_c = (st_q == 4'd0) ? ACCW'(bus.bias) : acc;
      sum_c  = base_c + ACCW'(prod_q);
      shf_c  = sum_c >>> SHIFT;
      sat_c  = shf_c[DW-1:0];
      if (shf_c < 0) begin
         sat_c = '0;
      end else if (shf_c > YMAX) begin
         sat_c = '1;
      end
   end

   // three-deep pipeline: sample, accumulate/finalise, present
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q      <= '0;
         st_q        <= '0;
         prev_state  <= '0;
         s1_vld      <= 1'b0;
         have_prev   <= 1'b0;
         err_q       <= 1'b0;
         win_vld     <= 1'b0;
         acc         <= '0;
         fin_q       <= '0;
         fin_vld     <= 1'b0;
         bus.y       <= '0;
         bus.y_valid <= 1'b0;
         bus.seq_err <= 1'b0;
      end else begin
         prod_q     <= prod_c;
         st_q       <= bus.state;
         prev_state <= bus.state;
         s1_vld     <= 1'b1;
         have_prev  <= 1'b1;
         err_q      <= viol_c;

         // a state-0 sample opens a window even if it is itself a violation
         if (bus.state == 4'd0) begin
            win_vld <= 1'b1;
         end else if (viol_c) begin
            win_vld <= 1'b0;
         end

         fin_vld <= 1'b0;
         if (s1_vld) begin
            acc <= sum_c;
            if ((st_q == 4'd15) && win_vld) begin
               fin_q   <= sat_c;
               fin_vld <= 1'b1;
            end
         end

         bus.seq_err <= err_q;
         bus.y_valid <= fin_vld;
         if (fin_vld) begin
            bus.y <= fin_q;
         end
      end
   end

endmodule
